// File: rtl/parking_exit_controller.sv
// ============================================================================
// Module   : parking_exit_controller
// Purpose  : Exit-side lot control: spot occupancy and timers, billing, exit
//            gate and spot release. Optional grace period: PARKING_GRACE_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module parking_exit_controller #(
  parameter int NUM_SPOTS    = 4,
  parameter int TIMER_W      = 8,
  parameter int FEE_W        = 12,
  parameter int RATE         = 3,
  parameter int GATE_TIMEOUT = 16,
  parameter int GRACE_TICKS  = 2,
  localparam int SW          = (NUM_SPOTS > 1) ? $clog2(NUM_SPOTS) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_tick,
  input  logic                 i_park_valid,
  input  logic [SW-1:0]        i_park_spot,
  input  logic                 i_exit_req,
  input  logic [SW-1:0]        i_exit_spot,
  input  logic                 i_car_passed,
  output logic [NUM_SPOTS-1:0] o_occupancy,
  output logic                 o_exit_busy,
  output logic [FEE_W-1:0]     o_fee,
  output logic                 o_fee_valid,
  output logic                 o_gate_open,
  output logic                 o_release_valid,
  output logic [SW-1:0]        o_release_spot,
  output logic                 o_err
);

  localparam int PW = FEE_W + TIMER_W;
  localparam int CW = $clog2(GATE_TIMEOUT) + 1;
  localparam logic [TIMER_W-1:0] c_timer_max = {TIMER_W{1'b1}};
  localparam logic [PW-1:0]      c_fee_max   = PW'({FEE_W{1'b1}});

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CHECK   = 3'd1,
    S_ERR     = 3'd2,
    S_BILL    = 3'd3,
    S_GATE    = 3'd4,
    S_RELEASE = 3'd5
  } state_t;

  state_t               r_state;
  logic [SW-1:0]        r_spot;
  logic [CW-1:0]        r_gcnt;
  logic [NUM_SPOTS-1:0] r_occ;
  logic [TIMER_W-1:0]   r_timer [NUM_SPOTS];
  logic                 r_busy;
  logic [FEE_W-1:0]     r_fee;
  logic                 r_fee_valid;
  logic                 r_gate_open;
  logic                 r_release_valid;
  logic [SW-1:0]        r_release_spot;
  logic                 r_err;

  logic [TIMER_W-1:0]   w_sel_timer;
  logic [PW-1:0]        w_prod;
  logic [FEE_W-1:0]     w_fee;
  logic                 w_park_err;

  assign w_sel_timer = r_timer[r_spot];
  // A spot mid-release still reads occupied, so a park to it is rejected.
  assign w_park_err  = i_park_valid & r_occ[i_park_spot];

`ifdef PARKING_GRACE_EN
  always_comb begin
    w_prod = '0;
    if (w_sel_timer > TIMER_W'(GRACE_TICKS))
      w_prod = PW'(w_sel_timer - TIMER_W'(GRACE_TICKS)) * PW'(RATE);
  end
`else
  logic w_unused_grace;
  assign w_unused_grace = ^GRACE_TICKS;
  always_comb begin
    w_prod = PW'(w_sel_timer) * PW'(RATE);
  end
`endif

  assign w_fee = (w_prod > c_fee_max) ? {FEE_W{1'b1}} : w_prod[FEE_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_occ <= '0;
      for (int i = 0; i < NUM_SPOTS; i++) r_timer[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_SPOTS; i++) begin
        if (r_state == S_RELEASE && r_spot == SW'(i)) begin
          r_occ[i]   <= 1'b0;
          r_timer[i] <= '0;
        end else if (i_park_valid && i_park_spot == SW'(i) && !r_occ[i]) begin
          r_occ[i]   <= 1'b1;
          r_timer[i] <= '0;
        end else if (!r_occ[i]) begin
          r_timer[i] <= '0;
        end else if (i_tick && r_timer[i] != c_timer_max &&
                     !(r_state != S_IDLE && r_spot == SW'(i))) begin
          r_timer[i] <= r_timer[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state         <= S_IDLE;
      r_spot          <= '0;
      r_gcnt          <= '0;
      r_busy          <= 1'b0;
      r_fee           <= '0;
      r_fee_valid     <= 1'b0;
      r_gate_open     <= 1'b0;
      r_release_valid <= 1'b0;
      r_release_spot  <= '0;
      r_err           <= 1'b0;
    end else begin
      r_fee_valid     <= 1'b0;
      r_release_valid <= 1'b0;
      r_err           <= w_park_err;
      case (r_state)
        S_IDLE: begin
          if (i_exit_req) begin
            r_spot  <= i_exit_spot;
            r_busy  <= 1'b1;
            r_state <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (!r_occ[r_spot]) begin
            r_err   <= 1'b1;
            r_state <= S_ERR;
          end else begin
            r_fee       <= w_fee;
            r_fee_valid <= 1'b1;
            r_state     <= S_BILL;
          end
        end
        S_ERR: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        S_BILL: begin
          r_gcnt      <= '0;
          r_gate_open <= 1'b1;
          r_state     <= S_GATE;
        end
        S_GATE: begin
          if (i_car_passed) begin
            r_gate_open     <= 1'b0;
            r_release_valid <= 1'b1;
            r_release_spot  <= r_spot;
            r_state         <= S_RELEASE;
          end else if (r_gcnt == CW'(GATE_TIMEOUT - 1)) begin
            r_gate_open <= 1'b0;
            r_err       <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= S_IDLE;
          end else begin
            r_gcnt <= r_gcnt + 1'b1;
          end
        end
        S_RELEASE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_gate_open <= 1'b0;
          r_busy      <= 1'b0;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  assign o_occupancy     = r_occ;
  assign o_exit_busy     = r_busy;
  assign o_fee           = r_fee;
  assign o_fee_valid     = r_fee_valid;
  assign o_gate_open     = r_gate_open;
  assign o_release_valid = r_release_valid;
  assign o_release_spot  = r_release_spot;
  assign o_err           = r_err;

endmodule

`default_nettype wire

// File: tb/tb_parking_exit_controller.sv
// ============================================================================
// Module   : tb_parking_exit_controller
// Purpose  : Directed self-checking bench for parking_exit_controller.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_parking_exit_controller;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       i_tick, i_park_valid, i_exit_req, i_car_passed;
  logic [1:0] i_park_spot, i_exit_spot;
  logic [3:0] o_occupancy;
  logic       o_exit_busy, o_fee_valid, o_gate_open, o_release_valid, o_err;
  logic [11:0] o_fee;
  logic [1:0] o_release_spot;

  int n_vec  = 0;
  int n_miss = 0;
  int gate_cycles = 0;

  always #5 clk = ~clk;

  always @(negedge clk) if (o_gate_open) gate_cycles++;

  parking_exit_controller dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_tick         (i_tick),
    .i_park_valid   (i_park_valid),
    .i_park_spot    (i_park_spot),
    .i_exit_req     (i_exit_req),
    .i_exit_spot    (i_exit_spot),
    .i_car_passed   (i_car_passed),
    .o_occupancy    (o_occupancy),
    .o_exit_busy    (o_exit_busy),
    .o_fee          (o_fee),
    .o_fee_valid    (o_fee_valid),
    .o_gate_open    (o_gate_open),
    .o_release_valid(o_release_valid),
    .o_release_spot (o_release_spot),
    .o_err          (o_err)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  function automatic int fee_exp(input int t);
    int f;
`ifdef PARKING_GRACE_EN
    f = (t <= 2) ? 0 : (t - 2) * 3;
`else
    f = t * 3;
`endif
    return (f > 4095) ? 4095 : f;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic park(input logic [1:0] s);
    i_park_valid = 1'b1;
    i_park_spot  = s;
    cyc();
    i_park_valid = 1'b0;
  endtask

  task automatic ticks(input int n);
    i_tick = 1'b1;
    repeat (n) cyc();
    i_tick = 1'b0;
  endtask

  // Full exit with the car clearing the gate in its third GATE cycle.
  task automatic do_exit(input logic [1:0] s, input int fee, input bit park_in_rel);
    i_exit_req  = 1'b1;
    i_exit_spot = s;
    cyc();
    i_exit_req  = 1'b0;
    gate_cycles = 0;
    chk("busy_check", o_exit_busy, 1);
    cyc();
    chk("fee_valid", o_fee_valid, 1);
    chk("fee", o_fee, fee);
    chk("gate_in_bill", o_gate_open, 0);
    cyc();
    chk("gate_open", o_gate_open, 1);
    chk("fee_valid_pulse", o_fee_valid, 0);
    cyc();
    cyc();
    chk("gate_open3", o_gate_open, 1);
    i_car_passed = 1'b1;
    cyc();
    i_car_passed = 1'b0;
    chk("release_valid", o_release_valid, 1);
    chk("release_spot", o_release_spot, s);
    chk("gate_closed", o_gate_open, 0);
    chk("gate_cycles", gate_cycles, 3);
    if (park_in_rel) begin
      i_park_valid = 1'b1;
      i_park_spot  = s;
    end
    cyc();
    i_park_valid = 1'b0;
    chk("release_pulse", o_release_valid, 0);
    chk("occ_cleared", o_occupancy[s], 0);
    chk("busy_idle", o_exit_busy, 0);
    chk("err_after_release", o_err, park_in_rel);
  endtask

  initial begin
    rst_n = 1'b0;
    i_tick = 0; i_park_valid = 0; i_exit_req = 0; i_car_passed = 0;
    i_park_spot = 0; i_exit_spot = 0;
    #2;
    chk("rst_occ", o_occupancy, 0);
    chk("rst_outputs", {o_exit_busy, o_fee_valid, o_gate_open, o_release_valid, o_err}, 0);
    chk("rst_fee", o_fee, 0);
    cyc();
    rst_n = 1'b1;
    cyc();

    // Normal exit after 5 ticks
    park(2'd1);
    chk("park_occ", o_occupancy, 4'b0010);
    ticks(5);
    do_exit(2'd1, fee_exp(5), 1'b0);

    // Exit from a free spot
    i_exit_req = 1'b1; i_exit_spot = 2'd2;
    cyc();
    i_exit_req = 1'b0;
    chk("free_err_early", o_err, 0);
    cyc();
    chk("free_err", o_err, 1);
    chk("free_no_fee", o_fee_valid, 0);
    chk("free_gate", o_gate_open, 0);
    cyc();
    chk("free_err_pulse", o_err, 0);
    chk("free_busy", o_exit_busy, 0);

    // Gate timeout; exit request while busy must be dropped silently
    park(2'd0);
    ticks(4);
    i_exit_req = 1'b1; i_exit_spot = 2'd0;
    cyc();
    i_exit_req = 1'b0;
    cyc();
    chk("to_fee", o_fee, fee_exp(4));
    cyc();
    chk("to_gate", o_gate_open, 1);
    i_exit_req = 1'b1; i_exit_spot = 2'd2;
    i_tick = 1'b1;
    cyc();
    i_exit_req = 1'b0;
    i_tick = 1'b0;
    repeat (14) cyc();
    chk("to_gate16", o_gate_open, 1);
    chk("to_no_err", o_err, 0);
    cyc();
    chk("to_err", o_err, 1);
    chk("to_gate_closed", o_gate_open, 0);
    chk("to_busy", o_exit_busy, 0);
    chk("to_occ", o_occupancy[0], 1);
    cyc();
    chk("to_no_drop_err", o_err, 0);
    chk("to_busy_after", o_exit_busy, 0);
    ticks(2);
    do_exit(2'd0, fee_exp(6), 1'b1);

    // Saturating timer and double park
    park(2'd3);
    ticks(300);
    park(2'd3);
    chk("dbl_park_err", o_err, 1);
    chk("dbl_park_occ", o_occupancy, 4'b1000);
    do_exit(2'd3, fee_exp(255), 1'b0);

    // Reset in GATE
    park(2'd1);
    ticks(1);
    i_exit_req = 1'b1; i_exit_spot = 2'd1;
    cyc();
    i_exit_req = 1'b0;
    cyc();
    cyc();
    chk("rg_gate", o_gate_open, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rg_gate_closed", o_gate_open, 0);
    chk("rg_occ", o_occupancy, 0);
    chk("rg_busy", o_exit_busy, 0);
    chk("rg_fee", o_fee, 0);
    cyc();
    rst_n = 1'b1;
    i_car_passed = 1'b1;
    cyc();
    i_car_passed = 1'b0;
    cyc();
    chk("rg_no_release", o_release_valid, 0);
    chk("rg_no_gate", o_gate_open, 0);

    // Grace-period boundary points
    park(2'd2);
    ticks(2);
    do_exit(2'd2, fee_exp(2), 1'b0);
    park(2'd2);
    ticks(6);
    do_exit(2'd2, fee_exp(6), 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

`default_nettype wire
